// File: rtl/onehot_decoder_seq_pkg.sv
// Shared constants for the one-hot encoder/decoder pair: state encoding and
// code/output widths, plus the decoder FSM state type.
package onehot_decoder_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_GAP  = ST_GAP
  } state_e;

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Decoder bus: code handshake from the upstream (master) and the decoded
// one-hot/status outputs back from the decoder (slave).
interface onehot_decoder_seq_if
  import onehot_decoder_seq_pkg::*;
#(
  parameter int CNT_W = 8
);

  // Handshake: a code transfers on a rising edge where code_valid && code_ready.
  // code_ready never looks at code_valid; the upstream holds code/code_valid
  // stable until the transfer happens, nothing is queued.
  logic                sel;
  logic                code_valid;
  logic [CODE_W-1:0]   code;
  logic                code_ready;
  logic [ONEHOT_W-1:0] y;
  logic                busy;
  logic [CNT_W-1:0]    dec_count;
  state_e              dbg_state;

  modport master (
    output sel, code_valid, code,
    input  code_ready, y, busy, dec_count, dbg_state
  );

  modport slave (
    input  sel, code_valid, code,
    output code_ready, y, busy, dec_count, dbg_state
  );

endinterface

// File: rtl/onehot_decoder_seq_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential 3-to-8 decoder: drives y[code] for HOLD_CYCLES, then forces a
// GAP_CYCLES idle gap before the next code is accepted.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  onehot_decoder_seq_if.slave bus
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [ONEHOT_W-1:0] ONE = {{(ONEHOT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] y_q, y_d;
  logic                busy_q, busy_d;
  logic                code_ready;
  logic                accept;

  assign code_ready = (state_q == S_IDLE) && bus.sel;
  assign accept     = bus.code_valid && code_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        y_d    = '0;
        busy_d = 1'b0;
        if (accept) begin
          y_d     = ONE << bus.code;
          busy_d  = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Dropping sel abandons the rest of the pulse immediately.
        if (!bus.sel) begin
          y_d     = '0;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          y_d = '0;
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        y_d = '0;
        if (!bus.sel || (cnt_q == 8'd0)) begin
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        y_d     = '0;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      y_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_dec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .count (bus.dec_count)
  );

  assign bus.code_ready = code_ready;
  assign bus.y          = y_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (default timing, and a short
// hold / no gap / 2-bit counter) share one stimulus and one schedule model.
module tb_onehot_decoder_seq;
  import onehot_decoder_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'd0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq_if #(.CNT_W(8)) bus_a ();
  onehot_decoder_seq_if #(.CNT_W(2)) bus_b ();

  assign bus_a.sel = sel;
  assign bus_a.code_valid = code_valid;
  assign bus_a.code = code;
  assign bus_b.sel = sel;
  assign bus_b.code_valid = code_valid;
  assign bus_b.code = code;

  onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  onehot_decoder_seq #(.HOLD_CYCLES(2), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  // ---------------- model ----------------
  // Each accept enqueues the whole future of the outputs: HOLD entries of the
  // one-hot value, GAP zero entries still busy, then one idle entry.
  localparam int HOLD_C [2] = '{4, 2};
  localparam int GAP_C  [2] = '{1, 0};
  localparam int MAX_C  [2] = '{255, 3};

  logic [8:0] exp_q [2][$];
  logic [7:0] exp_y [2];
  logic       exp_busy [2];
  int         exp_cnt [2];
  logic [8:0] cur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        exp_q[i].delete();
        exp_y[i] = 8'h00;
        exp_busy[i] = 1'b0;
        exp_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cur = 9'h000;
        if (!sel) begin
          exp_q[i].delete();
        end else begin
          if (exp_q[i].size() == 0 && code_valid) begin
            for (int h = 0; h < HOLD_C[i]; h++) exp_q[i].push_back({1'b1, 8'h01 << code});
            for (int g = 0; g < GAP_C[i]; g++) exp_q[i].push_back(9'h100);
            exp_q[i].push_back(9'h000);
            if (exp_cnt[i] < MAX_C[i]) exp_cnt[i]++;
          end
          if (exp_q[i].size() > 0) cur = exp_q[i].pop_front();
        end
        exp_y[i] = cur[7:0];
        exp_busy[i] = cur[8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("y_a", 32'(bus_a.y), 32'(exp_y[0]));
      chk("busy_a", 32'(bus_a.busy), 32'(exp_busy[0]));
      chk("cnt_a", 32'(bus_a.dec_count), 32'(exp_cnt[0]));
      chk("ready_a", 32'(bus_a.code_ready), 32'(sel && exp_q[0].size() == 0));
      chk("onehot0_a", 32'($onehot0(bus_a.y)), 32'd1);
      chk("y_b", 32'(bus_b.y), 32'(exp_y[1]));
      chk("busy_b", 32'(bus_b.busy), 32'(exp_busy[1]));
      chk("cnt_b", 32'(bus_b.dec_count), 32'(exp_cnt[1]));
      chk("ready_b", 32'(bus_b.code_ready), 32'(sel && exp_q[1].size() == 0));
      chk("onehot0_b", 32'($onehot0(bus_b.y)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus_a.code_ready && n < 200) begin
      step();
      n++;
    end
    chk("wait_ready", 32'(bus_a.code_ready), 32'd1);
  endtask

  // Returns one step after the accepting edge (first cycle of the pulse).
  task automatic send(input logic [2:0] c, input bit keep_valid);
    code = c;
    code_valid = 1'b1;
    wait_ready();
    step();
    if (!keep_valid) code_valid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic [7:0] one;

  initial begin
    one = 8'h01;
    sel = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_y", 32'(bus_a.y), 32'h00);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_cnt", 32'(bus_a.dec_count), 32'd0);
    chk("rst_ready", 32'(bus_a.code_ready), 32'd1);
    step();

    // basic decode of code 5
    send(3'd5, 1'b0);
    chk("basic_y_t1", 32'(bus_a.y), 32'h20);
    chk("basic_busy_t1", 32'(bus_a.busy), 32'd1);
    repeat (3) step();
    chk("basic_y_t4", 32'(bus_a.y), 32'h20);
    step();
    chk("basic_y_t5", 32'(bus_a.y), 32'h00);
    chk("basic_busy_t5", 32'(bus_a.busy), 32'd1);
    chk("basic_ready_t5", 32'(bus_a.code_ready), 32'd0);
    step();
    chk("basic_busy_t6", 32'(bus_a.busy), 32'd0);
    chk("basic_ready_t6", 32'(bus_a.code_ready), 32'd1);
    chk("basic_cnt", 32'(bus_a.dec_count), 32'd1);

    // sweep all codes with valid held high
    for (int c = 0; c < 8; c++) begin
      send(3'(c), 1'b1);
      chk("sweep_y", 32'(bus_a.y), 32'(one << c));
    end
    code_valid = 1'b0;
    wait_ready();
    chk("sweep_cnt", 32'(bus_a.dec_count), 32'd9);

    // backpressure: code 2 presented during the hold of code 6
    send(3'd6, 1'b0);
    code = 3'd2;
    code_valid = 1'b1;
    step();
    chk("bp_y_hold", 32'(bus_a.y), 32'h40);
    step();
    chk("bp_y_hold2", 32'(bus_a.y), 32'h40);
    wait_ready();
    step();
    code_valid = 1'b0;
    chk("bp_y_second", 32'(bus_a.y), 32'h04);
    chk("bp_cnt", 32'(bus_a.dec_count), 32'd11);

    // abort by dropping sel mid-hold
    wait_ready();
    send(3'd1, 1'b0);
    step();
    sel = 1'b0;
    #1;
    chk("abort_ready_sel0", 32'(bus_a.code_ready), 32'd0);
    step();
    chk("abort_y", 32'(bus_a.y), 32'h00);
    chk("abort_busy", 32'(bus_a.busy), 32'd0);
    chk("abort_ready_idle", 32'(bus_a.code_ready), 32'd0);
    step();
    sel = 1'b1;
    #1;
    chk("abort_ready_back", 32'(bus_a.code_ready), 32'd1);
    chk("abort_cnt", 32'(bus_a.dec_count), 32'd12);

    // short-hold / no-gap instance: one zero cycle between pulses, saturation
    chk("b_ready", 32'(bus_b.code_ready), 32'd1);
    code = 3'd3;
    code_valid = 1'b1;
    step();
    chk("b_y_t1", 32'(bus_b.y), 32'h08);
    step();
    chk("b_y_t2", 32'(bus_b.y), 32'h08);
    step();
    chk("b_y_gap", 32'(bus_b.y), 32'h00);
    step();
    chk("b_y_t4", 32'(bus_b.y), 32'h08);
    code_valid = 1'b0;
    chk("b_cnt_sat", 32'(bus_b.dec_count), 32'd3);

    // async reset in the middle of a hold
    wait_ready();
    send(3'd4, 1'b0);
    chk("ar_y_before", 32'(bus_a.y), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_y_a", 32'(bus_a.y), 32'h00);
    chk("ar_y_b", 32'(bus_b.y), 32'h00);
    chk("ar_busy", 32'(bus_a.busy), 32'd0);
    chk("ar_cnt", 32'(bus_a.dec_count), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("ar_ready", 32'(bus_a.code_ready), 32'd1);
    send(3'd7, 1'b0);
    chk("ar_y_after", 32'(bus_a.y), 32'h80);
    chk("ar_cnt_after", 32'(bus_a.dec_count), 32'd1);
    wait_ready();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Sequential 3-to-8 decoder: the receiving end of the 8-to-3 one-hot encoder path.
- Accepts a 3-bit code through a valid/ready handshake gated by `sel`.
- Drives the matching one-hot line of `y` for a programmable hold time, then enforces a programmable guard gap before it accepts the next code.
- Keeps a saturating count of decoded events for status/debug.

Parameters:
- HOLD_CYCLES, 4, number of cycles the decoded one-hot line stays high; legal range 1..255.
- GAP_CYCLES, 1, number of idle cycles with `y`=0 forced after each hold; legal range 0..255.
- CNT_W, 8, width of the decoded-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  1  block enable; 0 forces the idle/zero output, matching the encoder's `sel`=0 convention.
- code_valid  input  1  `code` is valid this cycle.
- code  input  3  binary index to decode, 0..7.
- code_ready  output  1  block can accept a code this cycle (combinational).
- y  output  8  registered one-hot output; `y[code]`=1 during hold.
- busy  output  1  registered; 1 in HOLD or GAP.
- dec_count  output  CNT_W  registered saturating count of accepted codes.

Behaviour:
- Reset (`rst_n`=0, asynchronous): state=IDLE, `y`=8'h00, `busy`=0, `dec_count`=0, hold/gap counter=0. Release is synchronous to the next clk edge.
- States: IDLE, HOLD, GAP.
- `code_ready` = (state==IDLE) && `sel`. It never depends on `code_valid`.
- Accept = `code_valid` && `code_ready`, sampled at the rising edge.
- IDLE:
  - On accept at edge T: `y` <= 1<<`code`, `busy` <= 1, counter <= HOLD_CYCLES-1, state <= HOLD.
  - `dec_count` increments at the same edge and saturates at all-ones.
  - Without accept: `y` stays 0.
- HOLD:
  - `y` holds the same one-hot value for exactly HOLD_CYCLES cycles, T+1 .. T+HOLD_CYCLES.
  - Counter decrements each cycle.
  - At counter==0: `y` <= 0. If GAP_CYCLES>0, counter <= GAP_CYCLES-1 and state <= GAP. Otherwise state <= IDLE and `busy` <= 0.
- GAP: `y`=0. Counter decrements; at 0, state <= IDLE and `busy` <= 0.
- Latency: accept edge to `y` valid is 1 cycle.
- Minimum accept-to-accept spacing is HOLD_CYCLES+GAP_CYCLES+1 cycles, because IDLE lasts at least one cycle. As a result, `y` always has at least one zero cycle between pulses.
- `code_valid` while `code_ready`=0: ignored. No queueing, no error; the upstream must hold valid until ready.
- `sel` falling in HOLD or GAP: on the next edge `y` <= 0, `busy` <= 0, state <= IDLE. The remaining hold/gap is abandoned and `dec_count` is unchanged.
- `sel`=0 in IDLE: `code_ready`=0 and `y`=0.
- Invariant: `y` is always 8'h00 or exactly one bit set.
- `dec_count` at all-ones: further accepts leave it at all-ones; the decode still occurs.
- Async reset mid-HOLD: `y` clears immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2;
  - code width constant CODE_W=3;
  - output width constant ONEHOT_W=8.
  These constants are shared with the encoder side.
- One natural sub-module: `sat_counter` (parameter CNT_W; ports clk, rst_n, inc, count) for `dec_count`.
- The FSM and the hold/gap timer stay in the top module.

Test Plan:
- Reset/idle: `rst_n` low for 3 cycles, then release with `sel`=1 and `code_valid`=0 -> `y`=8'h00, `busy`=0, `dec_count`=0, `code_ready`=1.
- Basic decode (HOLD=4, GAP=1): `code`=3'd5 accepted at edge T -> `y`=8'h20 for cycles T+1..T+4, then 8'h00; `busy`=1 from T+1 through T+5; `code_ready` returns at T+6; `dec_count`=1.
- Sweep all codes 0..7 back-to-back, with `code_valid` held high -> each pulse is 1<<code (8'h01 .. 8'h80); `dec_count`=8; at least one zero cycle between pulses; `y` is never multi-hot.
- Backpressure: assert `code`=3'd2 during HOLD of `code`=3'd6 -> `y` stays 8'h40; 3'd2 is decoded only after `code_ready` rises; `dec_count` advances by exactly 2.
- Abort: drop `sel` at T+2 of a hold on `code`=3'd1 -> `y`=8'h00 and `busy`=0 after the next edge; `code_ready`=0 while `sel`=0; re-raise `sel` -> `code_ready`=1 the next cycle.
- Saturation and GAP=0: CNT_W=2 and GAP_CYCLES=0, five accepts -> `dec_count` sticks at 2'b11; the inter-pulse zero gap is exactly 1 cycle. Also assert async reset mid-HOLD -> `y` clears without waiting for a clock edge.
